goertzel_detector: RTL and testbench

Single-bin tone-power detector placed directly downstream of the DC blocker in the receiver chain. It consumes the blocker's signed Q.4 sample stream (one `valid_i` strobe per sample, 10 MSPS nominal) and runs a Goertzel recursion tuned to the 457 kHz beacon frequency over fixed blocks of `BLOCK_LEN` samples. At the end of each block it emits one scaled, saturated power estimate with a one-cycle `valid_o` strobe.

---
 rtl/goertzel_pkg.sv | 35 +++
 rtl/goertzel_power.sv | 113 +++++++++++
 rtl/goertzel_detector.sv | 95 +++++++++
 tb/tb_goertzel_detector.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/goertzel_pkg.sv
// Shared types and helpers for the single-bin Goertzel tone detector.
// Power FSM encoding, 457 kHz @ 10 MSPS default coefficient, signed saturation.
package goertzel_pkg;

    typedef enum logic [2:0] {
        P_IDLE,
        P_SQ1,
        P_SQ2,
        P_CROSS,
        P_OUT
    } power_state_t;

    localparam int COEFF_W            = 18;
    localparam int COEFF_FRAC_DEFAULT = 16;
    // 2*cos(2*pi*457e3/10e6) in Q2.16
    localparam logic signed [COEFF_W-1:0] COEFF_457K_10M = 18'sd125706;

    localparam int SAT_W = 128;

    // Clamp v into the signed range of a w-bit number; caller takes the low w bits.
    function automatic logic signed [SAT_W-1:0] sat_signed(input logic signed [SAT_W-1:0] v,
                                                           input int w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (SAT_W'(1) <<< (w - 1)) - SAT_W'(1);
        lo = ~hi;
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/goertzel_power.sv
// Block power estimate from a Goertzel state snapshot: s1^2 + s2^2 - c*s1*s2, scaled and saturated.
// Latency: snapshot edge E0 -> outputs registered at E4, valid_o high the cycle after E4.
// No backpressure: a snapshot is only offered when the FSM is idle (blocks are >= 8 samples).
module goertzel_power
    import goertzel_pkg::*;
#(
    parameter logic signed [COEFF_W-1:0] COEFF = COEFF_457K_10M,
    parameter int COEFF_FRAC  = COEFF_FRAC_DEFAULT,
    parameter int STATE_W     = 32,
    parameter int POWER_W     = 32,
    parameter int POWER_SHIFT = 24
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear_i,
    input  logic                      snap_vld,
    input  logic signed [STATE_W-1:0] snap_s1_dat,
    input  logic signed [STATE_W-1:0] snap_s2_dat,
    input  logic                      snap_ovf,
    output logic                      valid_o,
    output logic [POWER_W-1:0]        power_o,
    output logic                      overflow_o
);

    localparam int ACC_W = 2 * STATE_W + 2;

    power_state_t              state;
    logic signed [STATE_W-1:0] s1_q;
    logic signed [STATE_W-1:0] s2_q;
    logic                      ovf_q;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   cs1;
    logic signed [ACC_W-1:0]   mul_a;
    logic signed [ACC_W-1:0]   mul_b;
    logic signed [ACC_W-1:0]   mul_r;
    logic signed [ACC_W-1:0]   acc_sh;
    logic [POWER_W-1:0]        power_sat;

    // One shared multiplier, operands steered by the FSM state.
    always_comb begin
        cs1   = (ACC_W'(COEFF) * ACC_W'(s1_q)) >>> COEFF_FRAC;
        mul_a = ACC_W'(s1_q);
        mul_b = ACC_W'(s1_q);
        case (state)
            P_SQ2: begin
                mul_a = ACC_W'(s2_q);
                mul_b = ACC_W'(s2_q);
            end
            P_CROSS: begin
                mul_a = cs1;
                mul_b = ACC_W'(s2_q);
            end
            default: ;
        endcase
        mul_r  = mul_a * mul_b;
        acc_sh = acc >>> POWER_SHIFT;
        if (acc[ACC_W-1])
            power_sat = '0;
        else if (|acc_sh[ACC_W-1:POWER_W])
            power_sat = '1;
        else
            power_sat = acc_sh[POWER_W-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= P_IDLE;
            s1_q       <= '0;
            s2_q       <= '0;
            ovf_q      <= 1'b0;
            acc        <= '0;
            valid_o    <= 1'b0;
            power_o    <= '0;
            overflow_o <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            if (clear_i) begin
                state <= P_IDLE;
            end else begin
                case (state)
                    P_IDLE: begin
                        if (snap_vld) begin
                            s1_q  <= snap_s1_dat;
                            s2_q  <= snap_s2_dat;
                            ovf_q <= snap_ovf;
                            state <= P_SQ1;
                        end
                    end
                    P_SQ1: begin
                        acc   <= mul_r;
                        state <= P_SQ2;
                    end
                    P_SQ2: begin
                        acc   <= acc + mul_r;
                        state <= P_CROSS;
                    end
                    P_CROSS: begin
                        acc   <= acc - mul_r;
                        state <= P_OUT;
                    end
                    P_OUT: begin
                        power_o    <= power_sat;
                        overflow_o <= ovf_q;
                        valid_o    <= 1'b1;
                        state      <= P_IDLE;
                    end
                    default: state <= P_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/goertzel_detector.sv
// Single-bin Goertzel tone-power detector over fixed blocks of BLOCK_LEN samples.
// Latency: last sample of a block at edge E0 -> power_o/overflow_o at E4, valid_o the cycle after.
// No backpressure: every valid_i & en_i & ~clear_i sample is consumed, one per cycle max.
module goertzel_detector
    import goertzel_pkg::*;
#(
    parameter int INPUT_DW    = 17,
    parameter int BLOCK_LEN   = 1000,
    parameter logic signed [COEFF_W-1:0] COEFF = COEFF_457K_10M,
    parameter int COEFF_FRAC  = COEFF_FRAC_DEFAULT,
    parameter int STATE_W     = 32,
    parameter int POWER_W     = 32,
    parameter int POWER_SHIFT = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en_i,
    input  logic                       clear_i,
    input  logic                       valid_i,
    input  logic signed [INPUT_DW-1:0] data_i,
    output logic                       valid_o,
    output logic [POWER_W-1:0]         power_o,
    output logic                       overflow_o
);

    localparam int CNT_W  = $clog2(BLOCK_LEN);
    localparam int PROD_W = STATE_W + COEFF_W;
    localparam int FULL_W = PROD_W + 2;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_LEN - 1);

    logic signed [STATE_W-1:0] s1;
    logic signed [STATE_W-1:0] s2;
    logic signed [STATE_W-1:0] s0;
    logic [CNT_W-1:0]          cnt;
    logic                      ovf_acc;
    logic signed [PROD_W-1:0]  prod;
    logic signed [FULL_W-1:0]  s0_full;
    logic signed [SAT_W-1:0]   s0_wide;
    logic signed [SAT_W-1:0]   s0_sat;
    logic                      sat_hit;
    logic                      accept;
    logic                      last;

    always_comb begin
        prod    = PROD_W'(COEFF) * PROD_W'(s1);
        s0_full = FULL_W'(data_i) + FULL_W'(prod >>> COEFF_FRAC) - FULL_W'(s2);
        s0_wide = SAT_W'(s0_full);
        s0_sat  = sat_signed(s0_wide, STATE_W);
        s0      = s0_sat[STATE_W-1:0];
        sat_hit = (s0_sat != s0_wide);
    end

    assign accept = valid_i & en_i & ~clear_i;
    assign last   = accept && (cnt == LAST_CNT);

    // The closing sample hands its results to the power stage and restarts the block in the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1      <= '0;
            s2      <= '0;
            cnt     <= '0;
            ovf_acc <= 1'b0;
        end else if (clear_i || last) begin
            s1      <= '0;
            s2      <= '0;
            cnt     <= '0;
            ovf_acc <= 1'b0;
        end else if (accept) begin
            s2      <= s1;
            s1      <= s0;
            cnt     <= cnt + CNT_W'(1);
            ovf_acc <= ovf_acc | sat_hit;
        end
    end

    goertzel_power #(
        .COEFF       (COEFF),
        .COEFF_FRAC  (COEFF_FRAC),
        .STATE_W     (STATE_W),
        .POWER_W     (POWER_W),
        .POWER_SHIFT (POWER_SHIFT)
    ) u_power (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (clear_i),
        .snap_vld    (last),
        .snap_s1_dat (s0),
        .snap_s2_dat (s1),
        .snap_ovf    (ovf_acc | sat_hit),
        .valid_o     (valid_o),
        .power_o     (power_o),
        .overflow_o  (overflow_o)
    );

endmodule

// File: tb/tb_goertzel_detector.sv
// Three detector configurations share one stimulus stream; a block-level Goertzel model predicts
// every result and its cycle, and directed steps pin the model with hand-derived values.
module tb_goertzel_detector;

    logic clk;
    logic rst;
    logic en_i;
    logic clear_i;
    logic valid_i;
    logic signed [16:0] data_i;
    logic        vo[3];
    logic [31:0] po[3];
    logic        oo[3];

    // index 0: 8-sample blocks, no shift; 1: defaults; 2: 24-bit state, no shift
    int bl[3] = '{8, 1000, 1000};
    int sw[3] = '{32, 32, 24};
    int ps[3] = '{0, 24, 0};
    localparam logic signed [127:0] COEF = 128'sd125706;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    goertzel_detector #(.BLOCK_LEN(8), .POWER_SHIFT(0)) u_small (
        .clk(clk), .rst(rst), .en_i(en_i), .clear_i(clear_i), .valid_i(valid_i), .data_i(data_i),
        .valid_o(vo[0]), .power_o(po[0]), .overflow_o(oo[0]));
    goertzel_detector u_main (
        .clk(clk), .rst(rst), .en_i(en_i), .clear_i(clear_i), .valid_i(valid_i), .data_i(data_i),
        .valid_o(vo[1]), .power_o(po[1]), .overflow_o(oo[1]));
    goertzel_detector #(.STATE_W(24), .POWER_SHIFT(0)) u_ovf (
        .clk(clk), .rst(rst), .en_i(en_i), .clear_i(clear_i), .valid_i(valid_i), .data_i(data_i),
        .valid_o(vo[2]), .power_o(po[2]), .overflow_o(oo[2]));

    int nchk = 0;
    int npass = 0;

    task automatic check(input string name, input longint act, input longint exp);
        nchk++;
        if (act === exp)
            npass++;
        else
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // ---------------- model ----------------
    int     blk[3][1000];
    int     nsmp[3];
    bit     pend[3];
    int     due[3];
    int     acc_edge[3];
    longint exp_p[3];
    bit     exp_o[3];
    int     cyc = 0;

    function automatic void block_power(input int k, output longint p, output bit ov);
        logic signed [127:0] s0, s1, s2, lim, acc;
        s1 = 0;
        s2 = 0;
        ov = 1'b0;
        lim = (128'sd1 <<< (sw[k] - 1)) - 1;
        for (int i = 0; i < bl[k]; i++) begin
            s0 = blk[k][i] + ((COEF * s1) >>> 16) - s2;
            if (s0 > lim) begin
                s0 = lim;
                ov = 1'b1;
            end else if (s0 < -lim - 1) begin
                s0 = -lim - 1;
                ov = 1'b1;
            end
            s2 = s1;
            s1 = s0;
        end
        acc = s1 * s1 + s2 * s2 - ((COEF * s1) >>> 16) * s2;
        if (acc < 0)
            acc = 0;
        acc = acc >>> ps[k];
        p = (acc > 128'sd4294967295) ? 64'd4294967295 : 64'(acc);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                nsmp[k] = 0;
                pend[k] = 1'b0;
            end
        end else begin
            cyc++;
            for (int k = 0; k < 3; k++) begin
                if (clear_i) begin
                    nsmp[k] = 0;
                    pend[k] = 1'b0;
                end else if (valid_i && en_i) begin
                    blk[k][nsmp[k]] = data_i;
                    nsmp[k]++;
                    if (nsmp[k] == bl[k]) begin
                        block_power(k, exp_p[k], exp_o[k]);
                        pend[k]     = 1'b1;
                        due[k]      = cyc + 4;
                        acc_edge[k] = cyc;
                        nsmp[k]     = 0;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    longint hold_p[3];
    bit     hold_o[3];
    int     nres[3];
    int     last_cyc[3];
    longint last_p[3];
    bit     last_o[3];

    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                hold_p[k] = 0;
                hold_o[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                bit exp_v;
                exp_v = pend[k] && (due[k] == cyc);
                check($sformatf("valid_o[%0d] cyc %0d", k, cyc), vo[k], exp_v);
                if (vo[k] === 1'b1) begin
                    nres[k]++;
                    last_cyc[k] = cyc;
                    last_p[k]   = po[k];
                    last_o[k]   = oo[k];
                end
                if (exp_v) begin
                    hold_p[k] = exp_p[k];
                    hold_o[k] = exp_o[k];
                end
                check($sformatf("power_o[%0d] cyc %0d", k, cyc), po[k], hold_p[k]);
                check($sformatf("overflow_o[%0d] cyc %0d", k, cyc), oo[k], hold_o[k]);
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic int tone(input real f, input real a, input int i);
        return $rtoi(a * $cos(6.283185307179586 * f * real'(i) / 1.0e7));
    endfunction

    task automatic drive(input bit v, input int d, input bit e = 1'b1, input bit c = 1'b0);
        @(negedge clk);
        valid_i = v;
        data_i  = 17'(d);
        en_i    = e;
        clear_i = c;
    endtask

    task automatic settle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid_i = 1'b0;
            en_i    = 1'b1;
            clear_i = 1'b0;
        end
        #1;
    endtask

    initial begin
        int     n0;
        int     c0;
        longint p0;
        rst     = 1'b0;
        en_i    = 1'b1;
        clear_i = 1'b0;
        valid_i = 1'b0;
        data_i  = '0;
        settle(3);
        check("reset_valid", vo[1], 0);
        check("reset_power", po[1], 0);
        check("reset_ovf", oo[1], 0);
        rst = 1'b1;

        // impulse on the 8-sample instance
        for (int i = 0; i < 7; i++) drive(1, 0);
        drive(1, 1000);
        settle(8);
        check("impulse_power", last_p[0], 1000000);
        check("impulse_ovf", last_o[0], 0);
        check("impulse_count", nres[0], 1);
        check("impulse_latency", last_cyc[0] - acc_edge[0], 4);
        drive(0, 0, 1, 1);
        settle(2);

        // two back-to-back on-tone blocks
        n0 = nres[1];
        c0 = 0;
        p0 = 0;
        for (int i = 0; i < 2000; i++) begin
            drive(1, tone(457.0e3, 16000.0, i % 1000));
            if (i == 1006) begin
                check("b2b_first_result", nres[1] - n0, 1);
                p0 = last_p[1];
                c0 = last_cyc[1];
            end
        end
        settle(8);
        check("b2b_count", nres[1] - n0, 2);
        check("b2b_identical", last_p[1], p0);
        check("b2b_spacing", last_cyc[1] - c0, 1000);
        check("tone_power_range", longint'(p0 >= 3619500 && p0 <= 4000500), 1);

        // off-tone rejection and silence
        for (int i = 0; i < 1000; i++) drive(1, tone(300.0e3, 16000.0, i));
        settle(8);
        check("offtone_reject", longint'(last_p[1] * 100 <= p0), 1);
        for (int i = 0; i < 1000; i++) drive(1, 0);
        settle(8);
        check("zero_power", last_p[1], 0);
        check("zero_ovf", last_o[1], 0);

        // enable low: strobes ignored, counter held
        n0 = nres[1];
        for (int i = 0; i < 500; i++) drive(1, (i % 13) * 100);
        for (int i = 0; i < 100; i++) drive(1, 3000, 0);
        for (int i = 0; i < 499; i++) drive(1, (i % 7) * 50);
        settle(8);
        check("en_counter_held", nres[1] - n0, 0);
        drive(1, 77);
        settle(8);
        check("en_block_done", nres[1] - n0, 1);

        // clear mid-block with a coincident strobe
        n0 = nres[1];
        for (int i = 0; i < 500; i++) drive(1, i);
        drive(1, 12345, 1, 1);
        for (int i = 0; i < 999; i++) drive(1, i);
        settle(8);
        check("clear_restart_early", nres[1] - n0, 0);
        drive(1, 5);
        settle(8);
        check("clear_restart_done", nres[1] - n0, 1);

        // clear sampled while the power FSM is in P_SQ2
        drive(0, 0, 1, 1);
        settle(1);
        n0 = nres[0];
        for (int i = 0; i < 8; i++) drive(1, 500 + i * 100);
        drive(0, 0);
        drive(0, 0, 1, 1);
        settle(8);
        check("clear_sq2_suppressed", nres[0] - n0, 0);

        // state saturation on the 24-bit instance
        n0 = nres[2];
        for (int i = 0; i < 1000; i++) drive(1, tone(457.0e3, 65535.0, i));
        settle(8);
        check("ovf_count", nres[2] - n0, 1);
        check("ovf_flag", last_o[2], 1);
        check("ovf_power_sat", last_p[2], 64'd4294967295);
        for (int i = 0; i < 1000; i++) drive(1, 0);
        settle(8);
        check("ovf_clear_flag", last_o[2], 0);
        check("ovf_clear_power", last_p[2], 0);

        // reset while the 8-sample instance has a result in flight
        for (int i = 0; i < 296; i++) drive(1, tone(457.0e3, 16000.0, i));
        drive(0, 0);
        #2 rst = 1'b0;
        #1;
        check("midreset_valid", vo[0], 0);
        check("midreset_power", po[0], 0);
        check("midreset_ovf", oo[0], 0);
        check("midreset_power_main", po[1], 0);
        settle(2);
        rst = 1'b1;
        n0 = nres[1];
        for (int i = 0; i < 999; i++) drive(1, tone(457.0e3, 16000.0, i));
        settle(8);
        check("post_reset_early", nres[1] - n0, 0);
        drive(1, tone(457.0e3, 16000.0, 999));
        settle(8);
        check("post_reset_count", nres[1] - n0, 1);
        check("post_reset_power", last_p[1], p0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
